// File: rtl/seq_detect_sched.sv
// Purpose: byte-to-bit scheduler feeding an overlapping serial pattern detector with match counting.
// Latency: a byte shifts out over DATA_W cycles; match is registered one cycle after its bit is on bit_out.
// Backpressure: in_ready is high only in WAIT, so at most one byte is taken every DATA_W+1 cycles.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   cfg_we, cfg_pattern, cfg_len,  configuration write (IDLE only): pattern (bit [len-1] oldest),
//   cfg_thresh                     length 2..PAT_MAX, irq threshold (0 disables irq)
//   start, stop                    begin a run from IDLE / end the run after the current byte
//   in_valid, in_data, in_ready    byte-wide valid/ready input
//   bit_out                        bit currently being shifted (0 outside SHIFT)
//   match, match_cnt, irq          detection pulse, saturating count, sticky threshold flag
//   busy                           high whenever the controller is not IDLE
module seq_detect_sched #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               bit_out,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               irq,
  output logic               busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [LEN_W-1:0]   LEN_MIN  = LEN_W'(2);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(PAT_MAX);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [PAT_MAX-1:0] PAT_RST  = PAT_MAX'(5'b10101);
  localparam logic [LEN_W-1:0]   LEN_RST  = LEN_W'(5);
  localparam logic [CNT_W-1:0]   THR_RST  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  // Only PAT_MAX-1 past bits are kept: together with the incoming bit they
  // form the full PAT_MAX-wide compare window, so the oldest bit is never needed.
  logic [PAT_MAX-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   vcnt_q, vcnt_d;
  logic               stop_pend_q, stop_pend_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;

  logic               bit_cur;
  logic [PAT_MAX-1:0] win_new;
  logic [LEN_W-1:0]   vcnt_inc;
  logic [PAT_MAX-1:0] len_mask;
  logic               len_ok;
  logic               hit;

  // Bit presented this cycle; forced low outside SHIFT so the diagnostic
  // output is quiet while idle or stalled.
  assign bit_cur  = (state_q == S_SHIFT) & shreg_q[DATA_W-1];

  // History as it will look after this cycle's bit is shifted in.
  assign win_new  = {hist_q, bit_cur};

  // Valid-bit count including the incoming bit, saturating at PAT_MAX.
  assign vcnt_inc = (vcnt_q == LEN_MAX) ? vcnt_q : vcnt_q + LEN_W'(1);

  assign len_ok   = (len_q >= LEN_MIN) && (len_q <= LEN_MAX);

  // Selects the low len bits of pattern and history for comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign hit = (vcnt_inc >= len_q) && (((win_new ^ pat_q) & len_mask) == '0);

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    hist_d      = hist_q;
    vcnt_d      = vcnt_q;
    stop_pend_d = stop_pend_q;
    pat_d       = pat_q;
    len_d       = len_q;
    thresh_d    = thresh_q;
    match_d     = 1'b0;
    cnt_d       = cnt_q;
    irq_d       = irq_q;

    unique case (state_q)
      S_IDLE: begin
        // A config write in the same cycle as start wins; the start is dropped.
        if (cfg_we) begin
          pat_d    = cfg_pattern;
          len_d    = cfg_len;
          thresh_d = cfg_thresh;
        end else if (start && len_ok) begin
          cnt_d   = '0;
          irq_d   = 1'b0;
          hist_d  = '0;
          vcnt_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // stop outranks a same-cycle transfer: the offered byte is not taken.
        if (stop) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          shreg_d     = in_data;
          idx_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        hist_d  = win_new[PAT_MAX-2:0];
        vcnt_d  = vcnt_inc;
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        idx_d   = idx_q + IDX_W'(1);
        match_d = hit;

        // irq fires only on the increment that lands on the threshold, so
        // a saturated counter sitting at the threshold does not re-trigger it.
        if (hit && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((thresh_q != '0) && (cnt_d == thresh_q)) begin
            irq_d = 1'b1;
          end
        end

        // A stop during the byte is remembered; the byte always finishes.
        if (stop) begin
          stop_pend_d = 1'b1;
        end

        if (idx_q == IDX_LAST) begin
          state_d     = (stop_pend_q || stop) ? S_IDLE : S_WAIT;
          stop_pend_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      hist_q      <= '0;
      vcnt_q      <= '0;
      stop_pend_q <= 1'b0;
      pat_q       <= PAT_RST;
      len_q       <= LEN_RST;
      thresh_q    <= THR_RST;
      match_q     <= 1'b0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      hist_q      <= hist_d;
      vcnt_q      <= vcnt_d;
      stop_pend_q <= stop_pend_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      thresh_q    <= thresh_d;
      match_q     <= match_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign in_ready  = (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign bit_out   = bit_cur;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Purpose: self-checking bench for seq_detect_sched using a per-cycle vector table and directed sequences.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: every wait on in_ready is bounded and an expired bound counts as a failure.
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_thresh;
  logic       start;
  logic       stop;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       bit_out;
  logic       match;
  logic [7:0] match_cnt;
  logic       irq;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_sched #(
    .DATA_W (8),
    .PAT_MAX(8),
    .LEN_W  (4),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_thresh (cfg_thresh),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .bit_out    (bit_out),
    .match      (match),
    .match_cnt  (match_cnt),
    .irq        (irq),
    .busy       (busy)
  );

  // One row per clock: {start, stop, in_valid}, in_data, and the outputs
  // expected before that clock edge as {in_ready, bit_out, match, irq, busy}.
  typedef struct {
    logic [2:0] ctl;
    logic [7:0] dat;
    logic [4:0] exp_o;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mkv(input logic [2:0] c, input logic [7:0] d,
                               input logic [4:0] e, input logic [7:0] n);
    vec_t v;
    v.ctl     = c;
    v.dat     = d;
    v.exp_o   = e;
    v.exp_cnt = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_thresh  = t;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk({name, " ready"}, 32'(in_ready), 32'd1);
  endtask

  // Sends one byte; m[k]/iq[k] hold match/irq seen right after bit k shifted.
  task automatic run_byte(input string name, input logic [7:0] d,
                          output logic [7:0] m, output logic [7:0] iq);
    m  = '0;
    iq = '0;
    wait_ready(name);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      m[k]  = match;
      iq[k] = irq;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m, iq;
    int cnt_a, cnt_b, cnt_c;

    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'h15; cfg_len = 4'd5; cfg_thresh = 8'd1;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step();
    step();
    rst = 1'b0;

    // Default config 10101/5/1, byte A8 = 1010_1000: match after bit 4.
    tbl[0]  = mkv(3'b100, 8'h00, 5'b00000, 8'd0);
    tbl[1]  = mkv(3'b001, 8'hA8, 5'b10001, 8'd0);
    tbl[2]  = mkv(3'b000, 8'h00, 5'b01001, 8'd0);
    tbl[3]  = mkv(3'b000, 8'h00, 5'b00001, 8'd0);
    tbl[4]  = mkv(3'b000, 8'h00, 5'b01001, 8'd0);
    tbl[5]  = mkv(3'b000, 8'h00, 5'b00001, 8'd0);
    tbl[6]  = mkv(3'b000, 8'h00, 5'b01001, 8'd0);
    tbl[7]  = mkv(3'b000, 8'h00, 5'b00111, 8'd1);
    tbl[8]  = mkv(3'b000, 8'h00, 5'b00011, 8'd1);
    tbl[9]  = mkv(3'b000, 8'h00, 5'b00011, 8'd1);
    tbl[10] = mkv(3'b010, 8'h00, 5'b10011, 8'd1);
    tbl[11] = mkv(3'b000, 8'h00, 5'b00010, 8'd1);

    for (int i = 0; i < 12; i++) begin
      {start, stop, in_valid} = tbl[i].ctl;
      in_data = tbl[i].dat;
      chk($sformatf("vec row %0d", i),
          {19'd0, in_ready, bit_out, match, irq, busy, match_cnt},
          {19'd0, tbl[i].exp_o, tbl[i].exp_cnt});
      step();
    end
    {start, stop, in_valid} = 3'b000;

    // Overlap across bytes: stream 00010101 01000000 matches at bits 7 and 9.
    do_cfg(8'h15, 4'd5, 8'd5);
    do_start();
    run_byte("ovl b0", 8'h15, m, iq);
    chk("ovl b0 match", 32'(m), 32'h80);
    run_byte("ovl b1", 8'h40, m, iq);
    chk("ovl b1 match", 32'(m), 32'h02);
    chk("ovl cnt", 32'(match_cnt), 32'd2);
    chk("ovl irq", 32'(irq), 32'd0);
    do_stop();

    // Pattern 111/3, thresh 3: FF matches on bits 2..7, irq from the 3rd.
    do_cfg(8'h07, 4'd3, 8'd3);
    do_start();
    run_byte("ones", 8'hFF, m, iq);
    chk("ones match", 32'(m), 32'hFC);
    chk("ones irq", 32'(iq), 32'hF0);
    chk("ones cnt", 32'(match_cnt), 32'd6);
    do_stop();
    do_start();
    chk("restart cnt", 32'(match_cnt), 32'd0);
    chk("restart irq", 32'(irq), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    do_stop();

    // in_valid held high: ready in 1 of every 9 cycles.
    do_cfg(8'h15, 4'd5, 8'd1);
    do_start();
    in_valid = 1'b1;
    in_data  = 8'h00;
    cnt_a = 0;
    for (int c = 0; c < 27; c++) begin
      cnt_a += int'(in_ready);
      step();
    end
    chk("ready duty", 32'(cnt_a), 32'd3);
    // Now in WAIT with in_valid high: stop must win over the transfer.
    stop = 1'b1;
    step();
    stop = 1'b0;
    in_valid = 1'b0;
    chk("stop prio busy", 32'(busy), 32'd0);
    chk("stop prio ready", 32'(in_ready), 32'd0);

    // 2A then 50 with a stall: 0010101001010000 contains 10101 only at bits 2..6.
    do_start();
    run_byte("stall a0", 8'h2A, m, iq);
    chk("stall a0 match", 32'(m), 32'h40);
    cnt_b = 0;
    for (int c = 0; c < 4; c++) begin
      cnt_b += int'(in_ready);
      step();
    end
    chk("stall ready held", 32'(cnt_b), 32'd4);
    run_byte("stall a1", 8'h50, m, iq);
    chk("stall a1 match", 32'(m), 32'h00);
    do_stop();
    // 15, stall, 40: the boundary-spanning match needs history kept through WAIT.
    do_start();
    run_byte("stall b0", 8'h15, m, iq);
    chk("stall b0 match", 32'(m), 32'h80);
    for (int c = 0; c < 4; c++) step();
    run_byte("stall b1", 8'h40, m, iq);
    chk("stall b1 match", 32'(m), 32'h02);
    chk("stall b cnt", 32'(match_cnt), 32'd2);
    do_stop();

    // Stop in the 3rd SHIFT cycle, cfg write attempted during SHIFT.
    do_start();
    wait_ready("stop run");
    in_valid = 1'b1;
    in_data  = 8'hA8;
    step();
    in_valid    = 1'b0;
    cfg_we      = 1'b1;
    cfg_pattern = 8'h07;
    cfg_len     = 4'd3;
    cfg_thresh  = 8'd3;
    step();
    cfg_we = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 0; c < 5; c++) begin
      cnt_a += int'(busy);
      cnt_b += int'(in_ready);
      cnt_c += int'(match);
      step();
    end
    chk("stop tail busy", 32'(cnt_a), 32'd5);
    chk("stop tail match", 32'(cnt_c), 32'd1);
    chk("stop idle busy", 32'(busy), 32'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cnt_b += int'(in_ready);
      step();
    end
    in_valid = 1'b0;
    chk("stop ready never", 32'(cnt_b), 32'd0);
    chk("stop cnt", 32'(match_cnt), 32'd1);
    // Config must still be 10101/5/1.
    do_start();
    run_byte("cfg kept", 8'hA8, m, iq);
    chk("cfg kept match", 32'(m), 32'h10);
    chk("cfg kept irq", 32'(iq), 32'hF0);
    do_stop();

    // Illegal lengths and cfg_we+start collisions keep the block idle.
    do_cfg(8'h01, 4'd1, 8'd1);
    do_start();
    chk("len1 busy", 32'(busy), 32'd0);
    do_cfg(8'hFF, 4'd9, 8'd1);
    do_start();
    chk("len9 busy", 32'(busy), 32'd0);
    cfg_we = 1'b1; cfg_pattern = 8'h15; cfg_len = 4'd5; cfg_thresh = 8'd1; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    chk("cfg wins busy", 32'(busy), 32'd0);
    do_stop();
    chk("idle stop busy", 32'(busy), 32'd0);
    do_start();
    chk("start ok busy", 32'(busy), 32'd1);
    do_stop();

    // Reset during SHIFT.
    do_cfg(8'h07, 4'd3, 8'd1);
    do_start();
    wait_ready("rst run");
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("pre-rst match", 32'(match), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post-rst outputs", {19'd0, in_ready, bit_out, match, irq, busy, match_cnt}, 32'd0);
    do_start();
    run_byte("rst cfg", 8'hA8, m, iq);
    chk("rst cfg match", 32'(m), 32'h10);
    chk("rst cfg irq", 32'(iq), 32'hF0);
    chk("rst cfg cnt", 32'(match_cnt), 32'd1);
    do_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
